bcd_scan_mux: RTL and testbench

//  Time-multiplexed scanner for an N-digit common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 11 +
 rtl/scan_prescaler.sv | 27 ++
 rtl/bcd_scan_mux.sv | 114 +++++++++++
 tb/tb_bcd_scan_mux.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
package seg_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic       AN_OFF  = 1'b1;

  function automatic logic bcd_valid(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..TICK_DIV-1 while enabled and
// flags the slot wrap and the leading anti-ghost dead interval.
module scan_prescaler #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16,
  localparam int unsigned PW         = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] pre,
  output logic          wrap,
  output logic          dead
);

  assign wrap = en && (pre == PW'(TICK_DIV - 1));
  assign dead = pre < PW'(DEAD_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      pre <= wrap ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scanner for an N-digit common-anode display: shadowed
// BCD capture with validation, leading-zero blanking and dead-time strobes.
module bcd_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    bcd_err,
  output logic                    frame_done
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [NUM_DIGITS-1:0][3:0] shadow, cap_nib;
  logic [NUM_DIGITS-1:0]      dp_shadow, inv_mask, cap_inv, lz_mask, blank_mask;
  logic [NUM_DIGITS-1:0]      an_next;
  logic [IW-1:0]              idx;
  logic [PW-1:0]              pre_unused;
  logic                       wrap, dead, last_digit;

  scan_prescaler #(
    .TICK_DIV   (TICK_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .pre (pre_unused),
    .wrap(wrap),
    .dead(dead)
  );

  always_comb begin
    cap_nib = '0;
    cap_inv = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_valid(digits_in[4*i +: 4])) cap_nib[i] = digits_in[4*i +: 4];
      else                                cap_inv[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
      inv_mask  <= '0;
      bcd_err   <= 1'b0;
    end else if (load) begin
      shadow    <= cap_nib;
      dp_shadow <= dp_in;
      inv_mask  <= cap_inv;
      if (|cap_inv) bcd_err <= 1'b1;
    end
  end

  // Walk from the most significant digit down; a digit stays blankable only
  // while it and everything above it are zero with no decimal point.
  always_comb begin
    logic        zeros_above;
    int unsigned k;
    lz_mask     = '0;
    zeros_above = blank_lz;
    k           = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      k           = NUM_DIGITS - 1 - i;
      zeros_above = zeros_above && (shadow[k] == 4'd0) && !dp_shadow[k];
      if (k != 0) lz_mask[k] = zeros_above;
    end
  end

  assign blank_mask = inv_mask | lz_mask;
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (wrap) begin
      idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    an_next = {NUM_DIGITS{AN_OFF}};
    if (en && !dead && !blank_mask[idx]) an_next[idx] = ~AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out    <= '0;
      dp_out     <= 1'b0;
      an         <= {NUM_DIGITS{AN_OFF}};
      frame_done <= 1'b0;
    end else begin
      bcd_out    <= shadow[idx];
      dp_out     <= dp_shadow[idx];
      an         <= an_next;
      frame_done <= wrap && last_digit;
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux with a time-indexed reference model.
module tb_bcd_scan_mux;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst, en, load, blank_lz;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  an;
  logic        bcd_err, frame_done;

  always #5 clk = ~clk;

  bcd_scan_mux #(
    .NUM_DIGITS (N),
    .TICK_DIV   (TD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out),
    .dp_out    (dp_out),
    .an        (an),
    .bcd_err   (bcd_err),
    .frame_done(frame_done)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: t counts enabled cycles since reset, so the slot phase
  // is t % TD and the digit is (t / TD) % N.
  int         t;
  int         sh[N];
  bit         dps[N];
  bit         inv[N];
  bit         err;
  logic [3:0] e_an, e_bcd;
  logic       e_dp, e_fd, e_err;
  bit         mon_on = 1'b0;

  function automatic bit blanked(input int k);
    if (inv[k]) return 1'b1;
    if (!blank_lz || k == 0) return 1'b0;
    for (int j = k; j < N; j++)
      if (sh[j] != 0 || dps[j]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int ph, d, v;
    if (rst) begin
      t = 0;
      err = 1'b0;
      for (int k = 0; k < N; k++) begin
        sh[k] = 0; dps[k] = 1'b0; inv[k] = 1'b0;
      end
      e_an = 4'hF; e_bcd = 4'h0; e_dp = 1'b0; e_fd = 1'b0; e_err = 1'b0;
    end else begin
      ph    = t % TD;
      d     = (t / TD) % N;
      e_bcd = 4'(sh[d]);
      e_dp  = dps[d];
      e_an  = 4'hF;
      if (en && ph >= DC && !blanked(d)) e_an[d] = 1'b0;
      e_fd  = en && ((t + 1) % (TD * N) == 0);
      if (en) t++;
      if (load) begin
        for (int k = 0; k < N; k++) begin
          v = int'(digits_in[4*k +: 4]);
          if (v > 9) begin sh[k] = 0; inv[k] = 1'b1; err = 1'b1; end
          else       begin sh[k] = v; inv[k] = 1'b0; end
          dps[k] = dp_in[k];
        end
      end
      e_err = err;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("an", 32'(an), 32'(e_an));
      check("bcd_out", 32'(bcd_out), 32'(e_bcd));
      check("dp_out", 32'(dp_out), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("bcd_err", 32'(bcd_err), 32'(e_err));
    end
  end

  int         cnt[N];
  logic [3:0] bcd_of[N];
  logic       dp_of[N];
  int         fd_cnt, off_cnt;

  task automatic observe(input int n);
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; bcd_of[k] = 4'hF; dp_of[k] = 1'b0;
    end
    fd_cnt = 0; off_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (an == 4'hF) off_cnt++;
      for (int k = 0; k < N; k++)
        if (an == ~(4'b0001 << k)) begin
          cnt[k]++; bcd_of[k] = bcd_out; dp_of[k] = dp_out;
        end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    digits_in = d; dp_in = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] v, input int lim, input string nm);
    int n = 0;
    while (an !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (an !== v) check({nm, "_timeout"}, 32'(an), 32'(v));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0;
    digits_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    check("rst_an", 32'(an), 32'h0F);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_err", 32'(bcd_err), 32'h0);

    rst = 1'b0; en = 1'b1;
    @(negedge clk); check("dead1_an", 32'(an), 32'hF);
    @(negedge clk); check("dead2_an", 32'(an), 32'hF);
    @(negedge clk); check("first_strobe", 32'(an), 32'b1110);

    do_load(16'h1234, 4'b0000);
    repeat (2) @(negedge clk);
    observe(32);
    for (int k = 0; k < N; k++) begin
      check($sformatf("h1234_cnt%0d", k), 32'(cnt[k]), 32'd6);
      check($sformatf("h1234_bcd%0d", k), 32'(bcd_of[k]), 32'(k + 1) % 5 == 0 ? 32'd0 : 32'(4 - k));
    end
    check("h1234_off", 32'(off_cnt), 32'd8);
    check("h1234_fd", 32'(fd_cnt), 32'd1);

    blank_lz = 1'b1;
    do_load(16'h0042, 4'b0000);
    repeat (2) @(negedge clk);
    observe(32);
    check("h0042_cnt0", 32'(cnt[0]), 32'd6);
    check("h0042_cnt1", 32'(cnt[1]), 32'd6);
    check("h0042_cnt23", 32'(cnt[2] + cnt[3]), 32'd0);
    check("h0042_bcd0", 32'(bcd_of[0]), 32'h2);
    check("h0042_bcd1", 32'(bcd_of[1]), 32'h4);

    do_load(16'h0000, 4'b0000);
    repeat (2) @(negedge clk);
    observe(32);
    check("h0000_cnt0", 32'(cnt[0]), 32'd6);
    check("h0000_cnt123", 32'(cnt[1] + cnt[2] + cnt[3]), 32'd0);
    check("h0000_bcd0", 32'(bcd_of[0]), 32'h0);

    blank_lz = 1'b0;
    do_load(16'h00A5, 4'b0000);
    check("inv_err_set", 32'(bcd_err), 32'h1);
    repeat (2) @(negedge clk);
    observe(32);
    check("inv_cnt0", 32'(cnt[0]), 32'd6);
    check("inv_cnt1", 32'(cnt[1]), 32'd0);
    check("inv_cnt2", 32'(cnt[2]), 32'd6);
    check("inv_bcd0", 32'(bcd_of[0]), 32'h5);
    do_load(16'h0005, 4'b0000);
    repeat (2) @(negedge clk);
    check("err_sticky", 32'(bcd_err), 32'h1);

    blank_lz = 1'b1;
    do_load(16'h0042, 4'b0100);
    repeat (2) @(negedge clk);
    observe(32);
    check("dp_cnt2", 32'(cnt[2]), 32'd6);
    check("dp_bcd2", 32'(bcd_of[2]), 32'h0);
    check("dp_dp2", 32'(dp_of[2]), 32'h1);
    check("dp_cnt3", 32'(cnt[3]), 32'd0);
    check("dp_bcd1", 32'(bcd_of[1]), 32'h4);

    // Load lands exactly on the digit-3 -> digit-0 wrap edge.
    blank_lz = 1'b0;
    wait_an(4'b1110, 40, "sync0");
    wait_an(4'b0111, 40, "sync3");
    repeat (4) @(negedge clk);
    do_load(16'h5678, 4'b0000);
    wait_an(4'b1110, 10, "boundary");
    check("boundary_bcd", 32'(bcd_out), 32'h8);

    wait_an(4'b1011, 40, "slot2");
    en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("frozen_an", 32'(an), 32'hF);
    end
    check("frozen_bcd", 32'(bcd_out), 32'h6);
    en = 1'b1;
    @(negedge clk);
    check("resume_an", 32'(an), 32'b1011);
    n = 1;
    @(negedge clk);
    while (an == 4'b1011 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("resume_len", 32'(n), 32'd5);

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_dp", 32'(dp_out), 32'h0);
    check("arst_err", 32'(bcd_err), 32'h0);
    check("arst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
